clk_div_multi: RTL and testbench

Multi-channel programmable clock divider for the sampling-clock path (ADC/DAC clocks, timebase ticks). Each of NCH channels divides `clk` by an even ratio chosen either from the decade table (÷2, ÷20 … ÷2·10^7) or as an arbitrary half-period count. Ratio changes go through a valid/ready configuration port and take effect only at a full-period boundary, so no runt pulses appear. A global `sync` strobe phase-aligns all channels.

---
 rtl/clk_div_multi.sv | 118 +++++++++++
 tb/tb_clk_div_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel divides clk by 2*(H+1).
// New ratios go through a valid/ready port and are applied only at a full-period boundary.
module clk_div_multi #(
  parameter int NCH   = 2,
  parameter int CNT_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           en,
  input  logic                     sync,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic                     cfg_mode,
  input  logic [2:0]               cfg_sel,
  input  logic [CNT_W-1:0]         cfg_half,
  output logic [NCH-1:0]           div_clk,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           pending
);

  localparam int CH_W = $clog2(NCH);

  // Decade table: terminal half-period count for divide by 2*10^sel.
  function automatic logic [CNT_W-1:0] decade_h(input logic [2:0] sel);
    logic [CNT_W-1:0] h;
    case (sel)
      3'd0:    h = CNT_W'(24'd0);
      3'd1:    h = CNT_W'(24'd9);
      3'd2:    h = CNT_W'(24'd99);
      3'd3:    h = CNT_W'(24'd999);
      3'd4:    h = CNT_W'(24'd9_999);
      3'd5:    h = CNT_W'(24'd99_999);
      3'd6:    h = CNT_W'(24'd999_999);
      3'd7:    h = CNT_W'(24'd9_999_999);
      default: h = CNT_W'(24'd0);
    endcase
    return h;
  endfunction

  logic [CNT_W-1:0] dec_h_s;
  logic [NCH-1:0]   hit_s;
  logic [NCH-1:0]   pend_r;
  logic [NCH-1:0]   div_r;
  logic [NCH-1:0]   tick_r;

  // Decoded terminal count of the incoming configuration request.
  always_comb begin
    dec_h_s = decade_h(cfg_sel);
    if (cfg_mode) begin
      dec_h_s = cfg_half;
    end else begin
      dec_h_s = decade_h(cfg_sel);
    end
  end

  // An out-of-range channel index matches no channel, so it is always ready
  // and the transfer is dropped.
  assign cfg_ready = ~|(hit_s & pend_r);

  assign div_clk = div_r;
  assign tick    = tick_r;
  assign pending = pend_r;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] act_h_r;
    logic [CNT_W-1:0] shd_h_r;
    logic             acc_s;

    assign hit_s[c] = (cfg_ch == CH_W'(c));
    assign acc_s    = cfg_valid & hit_s[c] & ~pend_r[c];

    // Channel counter, output toggle and shadow-ratio hand-over.
    always_ff @(posedge clk) begin
      if (rst) begin
        count_r   <= '0;
        act_h_r   <= '0;
        shd_h_r   <= '0;
        div_r[c]  <= 1'b0;
        tick_r[c] <= 1'b0;
        pend_r[c] <= 1'b0;
      end else if (sync || !en[c]) begin
        // Held or restarted channels take a pending ratio at once; a request
        // accepted in this same cycle stays pending (accept implies !pend_r).
        count_r   <= '0;
        div_r[c]  <= 1'b0;
        tick_r[c] <= 1'b0;
        if (acc_s) begin
          shd_h_r   <= dec_h_s;
          pend_r[c] <= 1'b1;
        end else if (pend_r[c]) begin
          act_h_r   <= shd_h_r;
          pend_r[c] <= 1'b0;
        end
      end else begin
        if (count_r == act_h_r) begin
          count_r   <= '0;
          div_r[c]  <= ~div_r[c];
          tick_r[c] <= ~div_r[c];
          // High-to-low toggle closes a full period: safe point to switch ratio.
          if (div_r[c] && pend_r[c]) begin
            act_h_r   <= shd_h_r;
            pend_r[c] <= 1'b0;
          end
        end else begin
          count_r   <= count_r + CNT_W'(1);
          tick_r[c] <= 1'b0;
        end
        if (acc_s) begin
          shd_h_r   <= dec_h_s;
          pend_r[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (three channels, so an
// out-of-range cfg_ch value exists).
module tb_clk_div_multi;
  localparam int NCH   = 3;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic             sync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = 2'd0;
  logic             cfg_mode = 1'b0;
  logic [2:0]       cfg_sel = 3'd0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [NCH-1:0]   div_clk;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_sel(cfg_sel), .cfg_half(cfg_half),
    .div_clk(div_clk), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 3'b111;
    repeat (3) step();
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL reset_div got=%b want=000", div_clk); end
    total++; if (tick !== 3'b000) begin bad++; $display("FAIL reset_tick got=%b want=000", tick); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL reset_pending got=%b want=000", pending); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
  endtask

  task automatic test_div2();
    logic [2:0] e;
    en  = 3'b011;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      e = (cyc % 2 == 1) ? 3'b011 : 3'b000;
      total++; if (div_clk !== e) begin bad++; $display("FAIL div2_div cyc=%0d got=%b want=%b", cyc, div_clk, e); end
      total++; if (tick !== e) begin bad++; $display("FAIL div2_tick cyc=%0d got=%b want=%b", cyc, tick, e); end
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL div2_pending cyc=%0d got=%b want=000", cyc, pending); end
    end
  endtask

  task automatic test_decade();
    logic [2:0] ed, et;
    int k;
    cfg_ch = 2'd0; cfg_mode = 1'b0; cfg_sel = 3'd1; cfg_valid = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL dec_ready got=%b want=1", cfg_ready); end
    step(); // cyc 7
    cfg_valid = 1'b0;
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL dec_pend_set got=%b want=001", pending); end
    total++; if (div_clk[0] !== 1'b1) begin bad++; $display("FAIL dec_old_high got=%b want=1", div_clk[0]); end
    step(); // cyc 8: old period ends, ratio applied
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL dec_pend_clr got=%b want=000", pending); end
    total++; if (div_clk[0] !== 1'b0) begin bad++; $display("FAIL dec_old_low got=%b want=0", div_clk[0]); end
    for (int i = 0; i < 40; i++) begin
      step();
      k  = cyc - 8;
      ed = {1'b0, cyc % 2 == 1, (k / 10) % 2 == 1};
      et = {1'b0, cyc % 2 == 1, k % 20 == 10};
      total++; if (div_clk !== ed) begin bad++; $display("FAIL dec_div cyc=%0d got=%b want=%b", cyc, div_clk, ed); end
      total++; if (tick !== et) begin bad++; $display("FAIL dec_tick cyc=%0d got=%b want=%b", cyc, tick, et); end
    end
  endtask

  task automatic test_direct();
    logic [2:0] ed, et;
    int j, k;
    step(); // cyc 49: ch1 high
    total++; if (div_clk[1] !== 1'b1) begin bad++; $display("FAIL dir_pre_high got=%b want=1", div_clk[1]); end
    cfg_ch = 2'd1; cfg_mode = 1'b1; cfg_half = 24'd2; cfg_valid = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL dir_ready got=%b want=1", cfg_ready); end
    step(); // cyc 50: accepted in high phase
    total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL dir_pend_set got=%b want=1", pending[1]); end
    total++; if (div_clk[1] !== 1'b0) begin bad++; $display("FAIL dir_c50 got=%b want=0", div_clk[1]); end
    cfg_half = 24'd5;
    #1;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL dir_stall got=%b want=0", cfg_ready); end
    step(); // cyc 51: second request not taken
    cfg_valid = 1'b0;
    total++; if (div_clk[1] !== 1'b1) begin bad++; $display("FAIL dir_c51 got=%b want=1", div_clk[1]); end
    total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL dir_pend_hold got=%b want=1", pending[1]); end
    step(); // cyc 52: apply
    total++; if (div_clk[1] !== 1'b0) begin bad++; $display("FAIL dir_c52 got=%b want=0", div_clk[1]); end
    total++; if (pending[1] !== 1'b0) begin bad++; $display("FAIL dir_pend_clr got=%b want=0", pending[1]); end
    for (int i = 0; i < 18; i++) begin
      step();
      j  = cyc - 52;
      k  = cyc - 8;
      ed = {1'b0, (j / 3) % 2 == 1, (k / 10) % 2 == 1};
      et = {1'b0, j % 6 == 3, k % 20 == 10};
      total++; if (div_clk !== ed) begin bad++; $display("FAIL dir_div cyc=%0d got=%b want=%b", cyc, div_clk, ed); end
      total++; if (tick !== et) begin bad++; $display("FAIL dir_tick cyc=%0d got=%b want=%b", cyc, tick, et); end
      total++; if (pending !== 3'b000) begin bad++; $display("FAIL dir_pending cyc=%0d got=%b want=000", cyc, pending); end
    end
  endtask

  task automatic test_sync();
    logic [2:0] ed, et, ep;
    int j;
    cfg_ch = 2'd0; cfg_mode = 1'b0; cfg_sel = 3'd2; cfg_valid = 1'b1;
    step(); // cyc 71
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL sync_pre_pend got=%b want=001", pending); end
    cfg_ch = 2'd1; cfg_mode = 1'b1; cfg_half = 24'd1; sync = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL sync_ready got=%b want=1", cfg_ready); end
    step(); // cyc 72
    sync = 1'b0; cfg_valid = 1'b0;
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL sync_div got=%b want=000", div_clk); end
    total++; if (tick !== 3'b000) begin bad++; $display("FAIL sync_tick got=%b want=000", tick); end
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL sync_pend got=%b want=010", pending); end
    for (int i = 0; i < 110; i++) begin
      step();
      j = cyc - 72;
      ed[0] = (j >= 100);
      et[0] = (j == 100);
      if (j < 3) ed[1] = 1'b0;
      else if (j < 6) ed[1] = 1'b1;
      else ed[1] = ((j - 6) / 2) % 2 == 1;
      et[1] = (j == 3) || (j >= 6 && (j - 6) % 4 == 2);
      ed[2] = 1'b0; et[2] = 1'b0;
      ep = {1'b0, j < 6, 1'b0};
      total++; if (div_clk !== ed) begin bad++; $display("FAIL sync_run_div cyc=%0d got=%b want=%b", cyc, div_clk, ed); end
      total++; if (tick !== et) begin bad++; $display("FAIL sync_run_tick cyc=%0d got=%b want=%b", cyc, tick, et); end
      total++; if (pending !== ep) begin bad++; $display("FAIL sync_run_pend cyc=%0d got=%b want=%b", cyc, pending, ep); end
    end
  endtask

  task automatic test_disable();
    logic [1:0] ed;
    en = 3'b010;
    step(); // cyc 183
    total++; if (div_clk[0] !== 1'b0 || tick[0] !== 1'b0) begin bad++; $display("FAIL dis_low got=%b%b want=00", div_clk[0], tick[0]); end
    cfg_ch = 2'd0; cfg_mode = 1'b0; cfg_sel = 3'd7; cfg_valid = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL dis_ready got=%b want=1", cfg_ready); end
    step(); // cyc 184
    cfg_valid = 1'b0;
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL dis_pend_set got=%b want=001", pending); end
    step(); // cyc 185
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL dis_pend_clr got=%b want=000", pending); end
    en = 3'b011;
    for (int i = 0; i < 20; i++) begin
      step();
      ed = {((cyc - 78) / 2) % 2 == 1, 1'b0};
      total++; if (div_clk[1:0] !== ed) begin bad++; $display("FAIL dis_run_div cyc=%0d got=%b want=%b", cyc, div_clk[1:0], ed); end
      total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL dis_run_tick cyc=%0d got=%b want=0", cyc, tick[0]); end
    end
  endtask

  task automatic test_oob();
    logic [2:0] ed;
    cfg_ch = 2'd3; cfg_mode = 1'b1; cfg_half = 24'd7; cfg_valid = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL oob_ready got=%b want=1", cfg_ready); end
    step(); // cyc 206
    cfg_valid = 1'b0;
    ed = {1'b0, ((cyc - 78) / 2) % 2 == 1, 1'b0};
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL oob_pend got=%b want=000", pending); end
    total++; if (div_clk !== ed) begin bad++; $display("FAIL oob_div got=%b want=%b", div_clk, ed); end
  endtask

  task automatic test_rst_mid();
    cfg_ch = 2'd1; cfg_mode = 1'b1; cfg_half = 24'd3; cfg_valid = 1'b1;
    step(); // cyc 207
    cfg_valid = 1'b0;
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL rstm_pend got=%b want=010", pending); end
    rst = 1'b1;
    step();
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL rstm_div got=%b want=000", div_clk); end
    total++; if (tick !== 3'b000) begin bad++; $display("FAIL rstm_tick got=%b want=000", tick); end
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL rstm_pending got=%b want=000", pending); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rstm_ready got=%b want=1", cfg_ready); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b0;
    en  = 3'b011;
    cyc = 0;
    step(); // 1
    total++; if (div_clk !== 3'b011) begin bad++; $display("FAIL b2b_c1 got=%b want=011", div_clk); end
    cfg_ch = 2'd0; cfg_mode = 1'b1; cfg_half = 24'd1; cfg_valid = 1'b1;
    step(); // 2
    total++; if (pending !== 3'b001) begin bad++; $display("FAIL b2b_pend0 got=%b want=001", pending); end
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL b2b_c2 got=%b want=000", div_clk); end
    cfg_ch = 2'd1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", cfg_ready); end
    step(); // 3
    cfg_valid = 1'b0;
    total++; if (pending !== 3'b011) begin bad++; $display("FAIL b2b_pend01 got=%b want=011", pending); end
    total++; if (div_clk !== 3'b011) begin bad++; $display("FAIL b2b_c3 got=%b want=011", div_clk); end
    step(); // 4
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL b2b_applied got=%b want=000", pending); end
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL b2b_c4 got=%b want=000", div_clk); end
    step(); // 5
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL b2b_c5 got=%b want=000", div_clk); end
    step(); // 6
    total++; if (div_clk !== 3'b011 || tick !== 3'b011) begin bad++; $display("FAIL b2b_c6 got=%b/%b want=011/011", div_clk, tick); end
    step(); // 7
    total++; if (div_clk !== 3'b011 || tick !== 3'b000) begin bad++; $display("FAIL b2b_c7 got=%b/%b want=011/000", div_clk, tick); end
    step(); // 8
    total++; if (div_clk !== 3'b000) begin bad++; $display("FAIL b2b_c8 got=%b want=000", div_clk); end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_decade();
    test_direct();
    test_sync();
    test_disable();
    test_oob();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
